// File: rtl/i2c_master_fsm_if.sv
// i2c_master_fsm_if: host request/response and SCL/SDA line bundle.
// master = host side (drives request, line inputs); slave = controller.
interface i2c_master_fsm_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       scl_in;
  logic       sda_in;
  logic       scl_out;
  logic       sda_out;
  logic       busy;
  logic       done;
  logic       nack;
  logic [7:0] rdata;

  modport master (
    output start, rw, addr, wdata,
    output scl_in, sda_in,
    input  scl_out, sda_out,
    input  busy, done, nack, rdata
  );

  modport slave (
    input  start, rw, addr, wdata,
    input  scl_in, sda_in,
    output scl_out, sda_out,
    output busy, done, nack, rdata
  );
endinterface

// File: rtl/i2c_master_fsm.sv
// i2c_master_fsm: single-byte I2C initiator, START/addr/data/STOP.
// Ports: pclk, preset (async high), bus (request, status, SCL/SDA).
module i2c_master_fsm #(
  parameter int CLK_DIV = 4
) (
  input  logic            pclk,
  input  logic            preset,
  i2c_master_fsm_if.slave bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_AACK  = 4'd3;
  localparam logic [3:0] S_WRITE = 4'd4;
  localparam logic [3:0] S_WACK  = 4'd5;
  localparam logic [3:0] S_READ  = 4'd6;
  localparam logic [3:0] S_MACK  = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;

  logic [3:0]    state;
  logic [3:0]    state_n;
  logic [1:0]    q;
  logic [DW-1:0] div;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic [7:0]    dreg;
  logic          rw_q;
  logic          ack_q;
  logic          stretch;
  logic          qend;
  logic          bend;
  logic          smp;
  logic          last;
  logic          scl_n;
  logic          sda_n;

  // Slave holding SCL low while we release it freezes Q2.
  assign stretch = (state != S_IDLE) && (q == 2'd2)
                && bus.scl_out && !bus.scl_in;
  assign qend = (state != S_IDLE) && (div == DMAX) && !stretch;
  assign bend = qend && (q == 2'd3);
  assign smp  = qend && (q == 2'd2);
  assign last = (bcnt == 3'd7);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_n = S_START;
      S_START: if (bend) state_n = S_ADDR;
      S_ADDR:  if (bend && last) state_n = S_AACK;
      S_AACK:  if (bend) state_n = ack_q ? S_STOP
                                 : (rw_q ? S_READ : S_WRITE);
      S_WRITE: if (bend && last) state_n = S_WACK;
      S_WACK:  if (bend) state_n = S_STOP;
      S_READ:  if (bend && last) state_n = S_MACK;
      S_MACK:  if (bend) state_n = S_STOP;
      S_STOP:  if (bend) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    scl_n = 1'b1;
    sda_n = 1'b1;
    case (state)
      S_IDLE: begin
        scl_n = 1'b1;
        sda_n = 1'b1;
      end
      S_START: begin
        scl_n = 1'b1;
        sda_n = ~q[1];
      end
      S_ADDR: begin
        scl_n = q[1];
        sda_n = shreg[7];
      end
      S_WRITE: begin
        scl_n = q[1];
        sda_n = dreg[7];
      end
      S_STOP: begin
        scl_n = q[1];
        sda_n = (q == 2'd3);
      end
      default: begin
        scl_n = q[1];
        sda_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= S_IDLE;
      q           <= 2'd0;
      div         <= '0;
      bcnt        <= 3'd0;
      shreg       <= 8'd0;
      dreg        <= 8'd0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      bus.scl_out <= 1'b1;
      bus.sda_out <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.nack    <= 1'b0;
      bus.rdata   <= 8'd0;
    end else begin
      state       <= state_n;
      bus.scl_out <= scl_n;
      bus.sda_out <= sda_n;
      bus.busy    <= (state_n != S_IDLE);
      bus.done    <= (state == S_STOP) && bend;
      if (state == S_IDLE) begin
        div  <= '0;
        q    <= 2'd0;
        bcnt <= 3'd0;
        if (bus.start) begin
          shreg    <= {bus.addr, bus.rw};
          dreg     <= bus.wdata;
          rw_q     <= bus.rw;
          bus.nack <= 1'b0;
        end
      end else begin
        if (stretch || div == DMAX) div <= '0;
        else div <= div + DW'(1);
        if (qend) q <= q + 2'd1;
        // Counter restarts whenever a new state is entered.
        if (bend) bcnt <= (state_n != state) ? 3'd0 : bcnt + 3'd1;
        if (smp) ack_q <= bus.sda_in;
        if (smp && state == S_READ)
          shreg <= {shreg[6:0], bus.sda_in};
        if (bend && state == S_ADDR)
          shreg <= {shreg[6:0], 1'b0};
        if (bend && state == S_WRITE)
          dreg <= {dreg[6:0], 1'b0};
        if (bend && state == S_READ && last)
          bus.rdata <= shreg;
        if (smp && bus.sda_in
            && (state == S_AACK || state == S_WACK))
          bus.nack <= 1'b1;
      end
    end
  end
endmodule

// File: doc/i2c_master_fsm.md
# i2c_master_fsm

Single-byte I2C controller (initiator) for the SCL/SDA bus served by the team's slave FSM. On a `start` request it generates START, sends a 7-bit address plus R/W, checks the address ACK, then either writes one data byte or reads one data byte, and finishes with STOP. SCL is derived from `pclk` by a quarter-period divider, and slave clock stretching is honoured. It sits between a register/host front-end and the open-drain pad logic.

## Interface
- `CLK_DIV`, default 4: `pclk` cycles per SCL quarter period. Legal values are ≥2. One bit time = 4*CLK_DIV cycles.
- `pclk` input, 1: system clock.
- `preset` input, 1: asynchronous, active-high reset.
- `start` input, 1: transaction request. Sampled only when `busy`=0.
- `rw` input, 1: 1 = read, 0 = write. Latched at accept.
- `addr` input, 7: slave address. Latched at accept.
- `wdata` input, 8: write byte. Latched at accept.
- `scl_in` input, 1: synchronised SCL line state, used for stretch detection.
- `sda_in` input, 1: synchronised SDA line state, used for ACK and read sampling.
- `scl_out` output, 1: 0 pulls SCL low, 1 releases it.
- `sda_out` output, 1: 0 pulls SDA low, 1 releases it.
- `busy` output, 1: transaction in progress.
- `done` output, 1: one-cycle completion pulse.
- `nack` output, 1: last transaction received a NACK. Valid from `done`, held until the next accept.
- `rdata` output, 8: byte read. Valid from `done`, held until the next read completes.

## Operation
- Reset values: `scl_out`=1, `sda_out`=1, `busy`=0, `done`=0, `nack`=0, `rdata`=0. State is IDLE, bit counter is 0, divider is 0.
- Accept: `start`=1 while `busy`=0.
  - Latches `{addr,rw}` into the shift register, `wdata` into the data register, and clears `nack`.
  - `busy` goes high the next cycle.
  - `start` while `busy`=1 is ignored.
- Each bit is four quarters, Q0 to Q3.
  - SCL is low in Q0 and Q1, and high in Q2 and Q3.
  - SDA changes only at the Q0 entry.
  - `sda_in` is sampled on the last cycle of Q2.
- States:
  - IDLE: both lines released. On accept, go to START.
  - START: SCL=1 throughout. SDA=1 in Q0–Q1 and SDA=0 in Q2–Q3. Go to ADDR.
  - ADDR: drive shift-register bits MSB first, 8 bits. Go to AACK.
  - AACK: SDA released. If the sample is 1, set `nack` and go to STOP. If the sample is 0, go to WRITE when `rw`=0, or READ when `rw`=1.
  - WRITE: drive `wdata` MSB first, 8 bits. Go to WACK.
  - WACK: SDA released. If the sample is 1, set `nack`. Go to STOP.
  - READ: SDA released. Shift each sample into the LSB, 8 bits. Then `rdata` ← shift register. Go to MACK.
  - MACK: SDA released (master NACK, end of read). Go to STOP.
  - STOP: SDA=0 in Q0–Q2 and SDA=1 in Q3. SCL=0 in Q0–Q1 and SCL=1 in Q2–Q3. Then go to IDLE.
- Bit counter is 3 bits. It clears on entry to ADDR, WRITE and READ, and increments at each Q3 end. The state exits when the counter wraps from 7.
- Clock stretching: while in Q2 with `scl_out`=1 and `scl_in`=0, the divider holds at 0 and does not advance. Q2 timing restarts once `scl_in`=1. Stretching applies in every state, including START and STOP.
- Completion: on the final STOP Q3 end, the next cycle has `done`=1, `busy`=0 and state IDLE, all together.
- A new `start` is accepted the cycle after `done`.

## Timing
- Divider counts 0..CLK_DIV-1. The quarter advances when the count is CLK_DIV-1.
- Accept to first SCL low (ADDR Q0): 1 + 4*CLK_DIV cycles.
- Full write or read with no stretching: 20 bit times = 80*CLK_DIV cycles, from the cycle after accept to `done`.
- Address NACK: START + 9 bits + STOP = 11 bit times = 44*CLK_DIV cycles.
- Output changes are registered, one cycle after the quarter boundary.
- Reset mid-transaction releases both lines immediately (asynchronous) and drops `busy`. No STOP is generated and `done` is not pulsed.

## Test plan
- Write, CLK_DIV=4, `addr`=7'h5A, `rw`=0, `wdata`=8'hC3, with the slave model ACKing both bytes.
  - Bus shows START, then 0xB4, ACK, 0xC3, ACK, STOP.
  - `done` is pulsed 320 cycles after accept, with `nack`=0.
- Read, `addr`=7'h21, `rw`=1, slave returns 8'h96.
  - Address byte is 0x43.
  - `rdata`=8'h96, the master's ninth bit is released (NACK), `nack`=0, and `done` comes at 320 cycles.
- Address NACK: slave never ACKs.
  - STOP follows the ninth bit.
  - `done` at 176 cycles with `nack`=1, and no data byte appears on the bus.
- Clock stretch: slave holds SCL low for 50 cycles during ADDR bit 3 Q2.
  - Sampling and remaining timing shift by exactly those 50 cycles.
  - `done` at 370 cycles, and data is intact.
- Reset and busy guard:
  - Pulse `start` during WRITE: it is ignored, and the latched data is unchanged.
  - Assert `preset` in WACK: `scl_out`=`sda_out`=1 and `busy`=0 immediately, with no `done` pulse.
  - A following transaction completes normally.
